// File: rtl/multi_blinker_pkg.sv
// Shared encodings for the multi-channel blinker: channel modes and the
// per-channel burst state machine states.
package multi_blinker_pkg;

  // Channel output modes as written through the configuration port.
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  // Burst sequencing: IDLE when not bursting, RUN while counting blinks,
  // DONE once the requested number of periods has elapsed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } burst_st_e;

endpackage

// File: rtl/multi_blinker_channel.sv
// One blink channel: configuration registers, rate tap select, falling-edge
// detect on the tap, burst state machine and the registered output.
module blinker_channel
  import multi_blinker_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [CNT_W-1:0]   cnt_i,
  input  logic               wr_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic [3:0]         cfg_rate_i,
  input  logic [CNT_W-1:0]   cfg_offset_i,
  input  logic [BURST_W-1:0] cfg_burst_i,
  output logic               blink_o,
  output logic               burst_done_o
);

  logic [1:0]         mode_q;
  logic [3:0]         rate_q;
  logic [CNT_W-1:0]   offset_q;
  logic [BURST_W-1:0] remaining_q;
  burst_st_e          state_q;
  logic               prev_tap_q;
  logic               blink_q;
  logic               done_q;

  logic tap_now;
  logic tap_new;
  logic tap_fall;

  // Tap of (cnt + offset) at bit 'rate'; rates past the top bit clamp to it.
  function automatic logic tap_of(input logic [CNT_W-1:0] cnt,
                                  input logic [CNT_W-1:0] offset,
                                  input logic [3:0]       rate);
    logic [CNT_W-1:0] phase;
    logic [3:0]       rate_eff;
    phase    = cnt + offset;
    rate_eff = (32'(rate) >= CNT_W) ? 4'(CNT_W - 1) : rate;
    return |(phase & (CNT_W'(1) << rate_eff));
  endfunction

  // Tap under the stored config, and under the config being written now so a
  // write can preload the edge detector and the output in the same cycle.
  assign tap_now  = tap_of(cnt_i, offset_q, rate_q);
  assign tap_new  = tap_of(cnt_i, cfg_offset_i, cfg_rate_i);
  assign tap_fall = prev_tap_q & ~tap_now;

  // Config load, edge tracking, burst sequencing and output register.
  // NOTE: the config fields are plain flops rather than a memory, so all of
  // them take the async reset; sequential state uses <= only, so every
  // branch below sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_OFF;
      rate_q      <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      state_q     <= ST_IDLE;
      prev_tap_q  <= 1'b0;
      blink_q     <= 1'b0;
      done_q      <= 1'b0;
    end else if (wr_i) begin
      // A write overrides any tap edge seen this cycle.
      mode_q      <= cfg_mode_i;
      rate_q      <= cfg_rate_i;
      offset_q    <= cfg_offset_i;
      remaining_q <= cfg_burst_i;
      prev_tap_q  <= tap_new;
      done_q      <= 1'b0;
      unique case (cfg_mode_i)
        MODE_OFF: begin
          state_q <= ST_IDLE;
          blink_q <= 1'b0;
        end
        MODE_ON: begin
          state_q <= ST_IDLE;
          blink_q <= 1'b1;
        end
        MODE_BLINK: begin
          state_q <= ST_IDLE;
          blink_q <= tap_new;
        end
        default: begin
          if (cfg_burst_i != '0) begin
            state_q <= ST_RUN;
            blink_q <= tap_new;
          end else begin
            state_q <= ST_DONE;
            blink_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
    end else if (ena) begin
      prev_tap_q <= tap_now;
      unique case (mode_q)
        MODE_OFF:   blink_q <= 1'b0;
        MODE_ON:    blink_q <= 1'b1;
        MODE_BLINK: blink_q <= tap_now;
        default: begin
          case (state_q)
            ST_RUN: begin
              if (tap_fall && remaining_q == BURST_W'(1)) begin
                remaining_q <= '0;
                state_q     <= ST_DONE;
                blink_q     <= 1'b0;
                done_q      <= 1'b1;
              end else begin
                if (tap_fall) remaining_q <= remaining_q - BURST_W'(1);
                blink_q <= tap_now;
              end
            end
            default: blink_q <= 1'b0;
          endcase
        end
      endcase
    end
  end

  assign blink_o      = blink_q;
  assign burst_done_o = done_q;

endmodule

// File: rtl/multi_blinker.sv
// Multi-channel blinker: one shared free-running counter, a one-cycle
// configuration write port, and CHANNELS independent blink channels.
module multi_blinker
  import multi_blinker_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int BURST_W  = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [3:0]          cfg_rate,
  input  logic [CNT_W-1:0]    cfg_offset,
  input  logic [BURST_W-1:0]  cfg_burst,
  output logic [CHANNELS-1:0] blink_out,
  output logic [CHANNELS-1:0] burst_done
);

  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [CHANNELS-1:0] wr_sel;

  assign cnt_d = ena ? cnt_q + CNT_W'(1) : cnt_q;

  // Shared phase counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Index values with no matching channel select nothing.
    assign wr_sel[i] = cfg_we & (cfg_ch == CH_W'(i));

    blinker_channel #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_channel (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .cnt_i        (cnt_q),
      .wr_i         (wr_sel[i]),
      .cfg_mode_i   (cfg_mode),
      .cfg_rate_i   (cfg_rate),
      .cfg_offset_i (cfg_offset),
      .cfg_burst_i  (cfg_burst),
      .blink_o      (blink_out[i]),
      .burst_done_o (burst_done[i])
    );
  end

endmodule

// File: tb/tb_multi_blinker.sv
// Directed bench for multi_blinker. A second instance with 5 channels and an
// 8-bit counter exercises the out-of-range channel index and rate clamping,
// which the 4-channel / 16-bit configuration cannot express on its ports.
module tb_multi_blinker;
  import multi_blinker_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;

  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_rate = '0;
  logic [15:0] cfg_offset = '0;
  logic [7:0] cfg_burst = '0;
  logic [3:0] blink_out;
  logic [3:0] burst_done;

  logic       cfg_we_b = 1'b0;
  logic [2:0] cfg_ch_b = '0;
  logic [1:0] cfg_mode_b = '0;
  logic [3:0] cfg_rate_b = '0;
  logic [7:0] cfg_offset_b = '0;
  logic [3:0] cfg_burst_b = '0;
  logic [4:0] blink_b;
  logic [4:0] done_b;

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt;

  always #5 clk = ~clk;

  multi_blinker #(.CHANNELS(4), .CNT_W(16), .BURST_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_rate   (cfg_rate),
    .cfg_offset (cfg_offset),
    .cfg_burst  (cfg_burst),
    .blink_out  (blink_out),
    .burst_done (burst_done)
  );

  multi_blinker #(.CHANNELS(5), .CNT_W(8), .BURST_W(4)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cfg_we     (cfg_we_b),
    .cfg_ch     (cfg_ch_b),
    .cfg_mode   (cfg_mode_b),
    .cfg_rate   (cfg_rate_b),
    .cfg_offset (cfg_offset_b),
    .cfg_burst  (cfg_burst_b),
    .blink_out  (blink_b),
    .burst_done (done_b)
  );

  // Reference counter: counts enabled edges since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   model_cnt <= 0;
    else if (ena) model_cnt <= model_cnt + 1;
  end

  // Expected tap for counter value c, offset, bit b, counter width w.
  function automatic logic exp_tap(input int c, input int off, input int b, input int w);
    int ph;
    ph = (c + off) & ((1 << w) - 1);
    return ((ph >> b) & 1) != 0;
  endfunction

  // All drives and samples happen just after a falling edge.
  task automatic wr_a(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] rate,
                      input logic [15:0] off, input logic [7:0] burst);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_rate = rate;
    cfg_offset = off; cfg_burst = burst;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] ch, input logic [1:0] mode, input logic [3:0] rate,
                      input logic [7:0] off, input logic [3:0] burst);
    cfg_we_b = 1'b1; cfg_ch_b = ch; cfg_mode_b = mode; cfg_rate_b = rate;
    cfg_offset_b = off; cfg_burst_b = burst;
    @(negedge clk);
    cfg_we_b = 1'b0;
  endtask

  task automatic align4();
    for (int k = 0; k < 4 && (model_cnt % 4) != 0; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (blink_out !== 4'h0 || burst_done !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_a: got blink=%b done=%b expected 0000/0000", blink_out, burst_done);
    end
    n_tests++;
    if (blink_b !== 5'h0 || done_b !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_b: got blink=%b done=%b expected 0/0", blink_b, done_b);
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (blink_out !== 4'h0 || burst_done !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_off: got blink=%b done=%b expected 0000/0000", blink_out, burst_done);
      end
    end
  endtask

  task automatic test_blink();
    logic e0;
    wr_a(2'd0, MODE_BLINK, 4'd2, 16'h0, 8'd0);
    for (int k = 0; k < 16; k++) begin
      e0 = exp_tap(model_cnt - 1, 0, 2, 16);
      n_tests++;
      if (blink_out[0] !== e0) begin
        n_fail++;
        $display("FAIL blink_ch0 k=%0d: got %b expected %b", k, blink_out[0], e0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_phase();
    logic [1:0] e;
    wr_a(2'd1, MODE_BLINK, 4'd2, 16'd4, 8'd0);
    for (int k = 0; k < 16; k++) begin
      e = {exp_tap(model_cnt - 1, 4, 2, 16), exp_tap(model_cnt - 1, 0, 2, 16)};
      n_tests++;
      if (blink_out[1:0] !== e || e[1] === e[0]) begin
        n_fail++;
        $display("FAIL phase_ch1 k=%0d: got %b expected %b (inverse pair)", k, blink_out[1:0], e);
      end
      @(negedge clk);
    end
  endtask

  task automatic run_burst(input string tag);
    int pulses, width, bad_width;
    logic prev;
    pulses = 0; width = 0; bad_width = 0; prev = 1'b0;
    align4();
    wr_a(2'd2, MODE_BURST, 4'd1, 16'h0, 8'd3);
    n_tests++;
    if (burst_done[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_clear: got %b expected 0", tag, burst_done[2]);
    end
    for (int k = 0; k < 40; k++) begin
      if (blink_out[2] && !prev) begin
        pulses++;
        width = 1;
      end else if (blink_out[2]) begin
        width++;
      end else if (prev && width != 2) begin
        bad_width++;
      end
      prev = blink_out[2];
      @(negedge clk);
    end
    n_tests++;
    if (pulses != 3 || bad_width != 0) begin
      n_fail++;
      $display("FAIL %s_pulses: got %0d pulses, %0d bad widths expected 3, 0", tag, pulses, bad_width);
    end
    n_tests++;
    if (blink_out[2] !== 1'b0 || burst_done[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_end: got blink=%b done=%b expected 0/1", tag, blink_out[2], burst_done[2]);
    end
  endtask

  task automatic test_burst();
    int highs, not_done, mism0;
    highs = 0; not_done = 0; mism0 = 0;
    run_burst("burst");
    for (int k = 0; k < 110; k++) begin
      if (blink_out[2] !== 1'b0) highs++;
      if (burst_done[2] !== 1'b1) not_done++;
      if (blink_out[0] !== exp_tap(model_cnt - 1, 0, 2, 16)) mism0++;
      @(negedge clk);
    end
    n_tests++;
    if (highs != 0 || not_done != 0) begin
      n_fail++;
      $display("FAIL burst_hold: got %0d high, %0d not-done cycles expected 0, 0", highs, not_done);
    end
    n_tests++;
    if (mism0 != 0) begin
      n_fail++;
      $display("FAIL burst_ch0_undisturbed: got %0d mismatching cycles expected 0", mism0);
    end
    run_burst("reburst");
  endtask

  task automatic test_burst_zero();
    int highs;
    highs = 0;
    wr_a(2'd3, MODE_BURST, 4'd1, 16'h0, 8'd0);
    n_tests++;
    if (burst_done[3] !== 1'b1 || blink_out[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL burst0: got done=%b blink=%b expected 1/0", burst_done[3], blink_out[3]);
    end
    for (int k = 0; k < 8; k++) begin
      if (blink_out[3] !== 1'b0) highs++;
      @(negedge clk);
    end
    n_tests++;
    if (highs != 0) begin
      n_fail++;
      $display("FAIL burst0_quiet: got %0d high cycles expected 0", highs);
    end
    wr_a(2'd3, MODE_ON, 4'd0, 16'h0, 8'd0);
    n_tests++;
    if (blink_out[3] !== 1'b1 || burst_done[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL on_after_burst0: got blink=%b done=%b expected 1/0", blink_out[3], burst_done[3]);
    end
  endtask

  task automatic test_hold_and_limits();
    logic [3:0] e;
    int mism;
    ena = 1'b0;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      if (k == 20) ena = 1'b1;
      e = {1'b1, 1'b0, exp_tap(model_cnt - 1, 4, 2, 16), exp_tap(model_cnt - 1, 0, 2, 16)};
      n_tests++;
      if (blink_out !== e || burst_done !== 4'b0100) begin
        n_fail++;
        $display("FAIL hold k=%0d: got blink=%b done=%b expected %b/0100", k, blink_out, burst_done, e);
      end
    end
    // cfg_rate is 4 bits, so a rate beyond the 16-bit counter cannot be
    // written here; the top tap is checked, and clamping is checked on dut_b.
    wr_a(2'd0, MODE_BLINK, 4'd15, 16'h8000, 8'd0);
    n_tests++;
    if (blink_out[0] !== exp_tap(model_cnt - 1, 16'h8000, 15, 16)) begin
      n_fail++;
      $display("FAIL rate15: got %b expected %b", blink_out[0], exp_tap(model_cnt - 1, 16'h8000, 15, 16));
    end
    wr_b(3'd0, MODE_BLINK, 4'd12, 8'h00, 4'd0);
    mism = 0;
    for (int k = 0; k < 150; k++) begin
      if (blink_b[0] !== exp_tap(model_cnt - 1, 0, 7, 8)) mism++;
      @(negedge clk);
    end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL rate_clamp: got %0d mismatching cycles expected 0", mism);
    end
    wr_b(3'd4, MODE_ON, 4'd0, 8'h00, 4'd0);
    wr_b(3'd5, MODE_ON, 4'd0, 8'h00, 4'd0);
    wr_b(3'd6, MODE_BURST, 4'd0, 8'h00, 4'd0);
    n_tests++;
    if (blink_b[4:1] !== 4'b1000 || done_b !== 5'h0) begin
      n_fail++;
      $display("FAIL bad_ch: got blink=%b done=%b expected 1000x/00000", blink_b, done_b);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] vec;
    vec = 12'b0000_1111_0000;
    align4();
    wr_a(2'd2, MODE_BURST, 4'd1, 16'h0, 8'd5);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (blink_out[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_burst_high: got %b expected 1", blink_out[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (blink_out !== 4'h0 || burst_done !== 4'h0 || blink_b !== 5'h0 || done_b !== 5'h0) begin
      n_fail++;
      $display("FAIL async_reset: got a=%b/%b b=%b/%b expected all 0", blink_out, burst_done, blink_b, done_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_a(2'd0, MODE_BLINK, 4'd2, 16'h0, 8'd0);
    for (int k = 0; k < 12; k++) begin
      n_tests++;
      if (blink_out !== {3'b000, vec[11-k]} || burst_done !== 4'h0) begin
        n_fail++;
        $display("FAIL restart k=%0d: got blink=%b done=%b expected %b/0000", k, blink_out, burst_done, {3'b000, vec[11-k]});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_phase();
    test_burst();
    test_burst_zero();
    test_hold_and_limits();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multi_blinker.md
Name: multi_blinker

Overview:
Parametrised multi-channel successor to the single-bit blinker, for the TinyTapeout top level. One shared free-running counter feeds CHANNELS independent channels. Each channel has its own rate tap, phase offset and mode: off, on, continuous blink, or a burst of N blinks followed by a stop. Channels are configured through a simple one-cycle write port driven by the top-level input pins.

Parameters:
- CHANNELS, 4, number of independent blink channels (1..8).
- CNT_W, 16, width of the shared counter, offsets and phase arithmetic.
- BURST_W, 8, width of the burst-count field.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, count enable. When low, the counter, channel state and outputs all hold.
- cfg_we, input, 1, configuration write strobe, one cycle.
- cfg_ch, input, $clog2(CHANNELS) (min 1), target channel index.
- cfg_mode, input, 2, 0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cfg_rate, input, 4, tap bit index into the phase value.
- cfg_offset, input, CNT_W, phase offset added to the counter.
- cfg_burst, input, BURST_W, number of blink periods in BURST mode.
- blink_out, output, CHANNELS, registered per-channel blink outputs.
- burst_done, output, CHANNELS, per-channel flag: burst finished.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - cnt=0; all channel modes OFF, rate=0, offset=0, remaining=0.
  - blink_out=0, burst_done=0, prev_tap=0, channel state IDLE.
- Counter: cnt <= cnt+1 every cycle with ena=1. Wraps modulo 2^CNT_W with no flag.
- Per channel i:
  - phase_i = (cnt + offset_i) mod 2^CNT_W, using CNT_W-bit arithmetic with the carry dropped.
  - tap_i = phase_i[min(rate_i, CNT_W-1)]. Rate values >= CNT_W clamp to CNT_W-1.
- Latency: blink_out[i] at cycle t+1 reflects cnt at cycle t. All outputs are registered.
- Output per mode:
  - OFF: 0.
  - ON: 1.
  - BLINK: tap_i.
  - BURST: tap_i while in RUN, 0 in IDLE or DONE.
- Blink period is 2^(rate+1) cycles at 50% duty.
- Config write (cfg_we=1, cfg_ch<CHANNELS):
  - Loads mode, rate, offset and remaining=cfg_burst into channel cfg_ch.
  - Clears burst_done[cfg_ch] and loads prev_tap with the new tap value, so no spurious edge is seen.
  - The new config takes effect on blink_out the following cycle.
  - Writes with cfg_ch >= CHANNELS are ignored.
  - Writes are accepted even when ena=0.
- Burst state machine, per channel: IDLE -> RUN -> DONE.
  - Writing mode BURST with cfg_burst>0 enters RUN.
  - Writing mode BURST with cfg_burst=0 enters DONE directly, with burst_done=1 and the output at 0.
  - In RUN, a falling edge of tap (prev_tap=1, tap=0, ena=1) decrements remaining.
  - The edge that takes remaining from 1 to 0 moves the channel to DONE: blink_out=0 and burst_done=1 from the next cycle.
  - DONE holds until the next write to that channel.
  - Writing any non-BURST mode sets the state to IDLE.
- Simultaneous events:
  - A write to channel i in the same cycle as a tap edge on i: the write wins, and the edge is discarded.
  - Writes to other channels do not disturb channel i.
- Mid-operation reset: all state returns immediately to the reset values above. There is no recovery of prior config.
- Unused input bits must be consumed by an _unused reduction wire, so the design stays lint-clean.

Decomposition:
- Package multi_blinker_pkg holds:
  - mode localparams MODE_OFF=2'd0, MODE_ON=2'd1, MODE_BLINK=2'd2, MODE_BURST=2'd3;
  - burst-state encodings ST_IDLE, ST_RUN, ST_DONE.
- Sub-module blinker_channel, instantiated CHANNELS times via generate:
  - holds the config registers, tap select, edge detect, burst FSM and output register;
  - the top level keeps the shared counter and the write decode.

Test Plan:
1. Reset, then write ch0 BLINK with rate=2, offset=0 -> blink_out[0] has period 8, pattern 0000 1111 repeating, one-cycle lag behind cnt[2].
2. Write ch1 BLINK with rate=2, offset=4, alongside ch0 from test 1 -> blink_out[1] is always the inverse of blink_out[0].
3. Write ch2 BURST with rate=1, burst=3 -> exactly 3 high pulses of 2 cycles each. Then blink_out[2]=0 and burst_done[2]=1, holding for 100 or more cycles. Rewriting BURST restarts the sequence and clears done.
4. Write ch3 BURST with burst=0 -> burst_done[3]=1 the next cycle and blink_out[3] stays 0. Write ch3 ON -> blink_out[3]=1 next cycle and burst_done[3]=0.
5. Hold ena=0 for 20 cycles mid-blink -> counter and all outputs freeze. Write ch0 with rate=20 -> behaves as rate 15. Write with cfg_ch=5 (CHANNELS=4) -> no channel changes.
6. Assert rst_n low asynchronously mid-burst on ch2 -> all outputs are 0 immediately. After release, all channels are OFF and cnt restarts from 0.
